// File: rtl/mdu_sequencer.sv
// mdu_sequencer: multiply/divide sequencer for the EX stage.
// Launches mult/multu/div/divu and computes the result in the launch cycle.
// The result is held in pending registers while a down-counter models the
// unit latency. On the last busy cycle the pending result commits to HI/LO.
// mthi/mtlo write HI/LO directly. mfhi/mflo read them on mdOut.
//
// Ports:
//   clk    in   core clock, rising edge
//   reset  in   asynchronous, active-high reset
//   en     in   EX-stage instruction valid
//   mdOp   in   [3:0] operation code (1 mult .. 8 mtlo, others none)
//   srcA   in   [31:0] rs operand
//   srcB   in   [31:0] rt operand
//   start  out  launch strobe (combinational)
//   busy   out  operation in flight (registered)
//   hi     out  [31:0] HI register
//   lo     out  [31:0] LO register
//   mdOut  out  [31:0] mfhi/mflo read data (combinational)
module mdu_sequencer #(
    parameter int unsigned MULT_CYCLES = 5,
    parameter int unsigned DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        en,
    input  logic [3:0]  mdOp,
    input  logic [31:0] srcA,
    input  logic [31:0] srcB,
    output logic        start,
    output logic        busy,
    output logic [31:0] hi,
    output logic [31:0] lo,
    output logic [31:0] mdOut
);

    localparam int unsigned MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int unsigned CNT_W      = $clog2(MAX_CYCLES + 1);

    typedef enum logic [3:0] {
        OP_NONE  = 4'd0,
        OP_MULT  = 4'd1,
        OP_MULTU = 4'd2,
        OP_DIV   = 4'd3,
        OP_DIVU  = 4'd4,
        OP_MFHI  = 4'd5,
        OP_MFLO  = 4'd6,
        OP_MTHI  = 4'd7,
        OP_MTLO  = 4'd8
    } mdOpT;

    typedef enum logic {
        IDLE,
        BUSY
    } stateT;

    stateT             state, stateNext;
    logic [CNT_W-1:0]  counter, counterNext;
    logic              busyNext;
    logic [31:0]       hiNext, loNext;
    logic [31:0]       pendHi, pendLo, pendHiNext, pendLoNext;
    logic              pendWrite, pendWriteNext;

    logic              isArith;
    logic [63:0]       extA, extB, prodS, prodU;
    logic [31:0]       divisor, absA, absB, qMag, rMag, quoS, remS, quoU, remU;

    assign isArith = (mdOp == OP_MULT) || (mdOp == OP_MULTU) ||
                     (mdOp == OP_DIV)  || (mdOp == OP_DIVU);
    assign start   = en & isArith & ~busy;

    always_comb begin
        mdOut = '0;
        if (mdOp == OP_MFHI)
            mdOut = hi;
        else if (mdOp == OP_MFLO)
            mdOut = lo;
    end

    // Low 64 bits of a product of sign-extended operands equal the signed product.
    assign extA  = {{32{srcA[31]}}, srcA};
    assign extB  = {{32{srcB[31]}}, srcB};
    assign prodS = extA * extB;
    assign prodU = {32'd0, srcA} * {32'd0, srcB};

    // Divide-by-zero never commits; a dummy divisor of 1 keeps the datapath defined.
    assign divisor = (srcB == '0) ? 32'd1 : srcB;
    assign quoU    = srcA / divisor;
    assign remU    = srcA % divisor;

    // Signed divide on magnitudes: 0x80000000 / -1 yields 0x80000000 rem 0 naturally.
    assign absA = srcA[31] ? (~srcA + 32'd1) : srcA;
    assign absB = divisor[31] ? (~divisor + 32'd1) : divisor;
    assign qMag = absA / absB;
    assign rMag = absA % absB;
    assign quoS = (srcA[31] ^ divisor[31]) ? (~qMag + 32'd1) : qMag;
    assign remS = srcA[31] ? (~rMag + 32'd1) : rMag;

    always_comb begin
        stateNext     = state;
        counterNext   = counter;
        busyNext      = busy;
        hiNext        = hi;
        loNext        = lo;
        pendHiNext    = pendHi;
        pendLoNext    = pendLo;
        pendWriteNext = pendWrite;
        case (state)
            IDLE: begin
                if (start) begin
                    stateNext     = BUSY;
                    busyNext      = 1'b1;
                    pendWriteNext = 1'b1;
                    counterNext   = CNT_W'(DIV_CYCLES);
                    case (mdOp)
                        OP_MULT: begin
                            counterNext = CNT_W'(MULT_CYCLES);
                            pendHiNext  = prodS[63:32];
                            pendLoNext  = prodS[31:0];
                        end
                        OP_MULTU: begin
                            counterNext = CNT_W'(MULT_CYCLES);
                            pendHiNext  = prodU[63:32];
                            pendLoNext  = prodU[31:0];
                        end
                        OP_DIV: begin
                            pendHiNext    = remS;
                            pendLoNext    = quoS;
                            pendWriteNext = (srcB != '0);
                        end
                        default: begin
                            pendHiNext    = remU;
                            pendLoNext    = quoU;
                            pendWriteNext = (srcB != '0);
                        end
                    endcase
                end else if (en) begin
                    if (mdOp == OP_MTHI)
                        hiNext = srcA;
                    else if (mdOp == OP_MTLO)
                        loNext = srcA;
                end
            end
            BUSY: begin
                counterNext = counter - CNT_W'(1);
                if (counter == CNT_W'(1)) begin
                    stateNext     = IDLE;
                    busyNext      = 1'b0;
                    pendWriteNext = 1'b0;
                    if (pendWrite) begin
                        hiNext = pendHi;
                        loNext = pendLo;
                    end
                end
            end
            default: stateNext = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            counter   <= '0;
            busy      <= 1'b0;
            hi        <= '0;
            lo        <= '0;
            pendHi    <= '0;
            pendLo    <= '0;
            pendWrite <= 1'b0;
        end else begin
            state     <= stateNext;
            counter   <= counterNext;
            busy      <= busyNext;
            hi        <= hiNext;
            lo        <= loNext;
            pendHi    <= pendHiNext;
            pendLo    <= pendLoNext;
            pendWrite <= pendWriteNext;
        end
    end

endmodule

// File: doc/mdu_sequencer.md
Name: mdu_sequencer

Overview:
Multiply/divide unit controller for the pipelined MIPS core, instantiated in the EX stage.
- Accepts mult/multu/div/divu, mfhi/mflo and mthi/mtlo operations.
- Sequences the multi-cycle latency with a down-counter and owns the HI/LO registers.
- Drives the start/busy pair consumed by the hazard unit's MDU stall condition.

Parameters:
MULT_CYCLES, 5, busy cycles for mult/multu (must be >= 1)
DIV_CYCLES, 10, busy cycles for div/divu (must be >= 1)

Ports:
clk  input  1  core clock, rising-edge active
reset  input  1  asynchronous, active-high reset
en  input  1  EX-stage instruction valid; low for bubbles and flushed slots
mdOp  input  4  0 none, 1 mult, 2 multu, 3 div, 4 divu, 5 mfhi, 6 mflo, 7 mthi, 8 mtlo, 9-15 none
srcA  input  32  rs operand, already forwarded
srcB  input  32  rt operand, already forwarded
start  output  1  combinational; en & mdOp in {1..4} & ~busy
busy  output  1  registered; high while an operation is in flight
hi  output  32  HI register
lo  output  32  LO register
mdOut  output  32  combinational; hi for mfhi, lo for mflo, else 0

Behaviour:
- Clock and reset: one clock (clk). reset is asynchronous and active-high; any assertion takes effect immediately, independent of clk.
- State machine: IDLE, BUSY.
- Reset values:
  - state = IDLE, busy = 0, counter = 0, hi = 0, lo = 0.
  - Pending result registers = 0, pending op = none.
  - start and mdOut follow their combinational definitions with en/mdOp.
- IDLE, start high at edge T:
  - Compute the result from srcA/srcB in the same cycle; latch it into pendHi/pendLo.
  - Load counter = MULT_CYCLES or DIV_CYCLES.
  - Go to BUSY; busy is high from T+1.
- BUSY, each edge: counter decrements.
  - When counter == 1 at an edge: commit pendHi/pendLo to hi/lo, clear busy, go to IDLE.
  - busy is therefore high for exactly N cycles after the start cycle.
  - New hi/lo are visible in the first cycle busy is low.
- Arithmetic:
  - mult: 64-bit signed product; hi = [63:32], lo = [31:0].
  - multu: same, operands treated as unsigned.
  - div: lo = signed quotient truncated toward zero; hi = remainder with the sign of the dividend.
  - divu: unsigned quotient and remainder.
- Divide by zero (srcB == 0):
  - The operation still runs the full DIV_CYCLES with busy high.
  - hi/lo are left unchanged at commit.
- Signed overflow div 0x80000000 / 0xFFFFFFFF: lo = 0x80000000, hi = 0.
- mthi/mtlo: with en high, state IDLE and start low, write srcA into hi or lo at the edge.
- mfhi/mflo: mdOut reads the current hi/lo combinationally, with no internal bypass.
- Hazard contract: the hazard unit stalls any md/mt/mf instruction in D while start|busy. Consequences:
  - start is never asserted while busy.
  - mt and mf are never issued in the start cycle or during BUSY.
- Defensive behaviour if the hazard contract is violated:
  - mult/div ops while busy: ignored, with start held low by definition.
  - mt ops while busy: ignored; hi/lo are not written.
  - mf ops while busy: return the old hi/lo.
- en low: no state change except the in-flight countdown, which continues. A flush does not cancel a launched operation.
- reset mid-operation: returns to IDLE immediately; busy = 0, hi/lo = 0, pending result discarded.
- Simultaneous commit edge and a new op: impossible, because busy is still high in the commit cycle, so start = 0.
- mdOp 0 or 9-15: no effect.

Test Plan:
- Reset behaviour: assert reset asynchronously between edges -> busy, hi, lo read 0 before the next clk edge.
- mult signed: srcA=0xFFFFFFFD, srcB=5, start pulse at T:
  - busy high T+1..T+5, low at T+6.
  - hi=0xFFFFFFFF, lo=0xFFFFFFF1 at T+6.
- multu then divu:
  - multu 0xFFFFFFFF × 2 -> hi=0x00000001, lo=0xFFFFFFFE.
  - divu 7 / 2 -> busy for 10 cycles, then lo=3, hi=1.
- div signed and divide by zero:
  - div 0xFFFFFFF9 (-7) / 2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF.
  - Next, div 5 / 0 -> busy 10 cycles, hi/lo unchanged.
- mthi/mtlo/mfhi/mflo:
  - mthi 0x12345678, then mflo/mfhi -> mdOut = lo, then 0x12345678.
  - mfhi issued while busy (contract violation) -> old hi returned; mt issued while busy -> ignored.
- Reset mid-op: start div, assert reset at busy cycle 4 -> busy=0 and hi/lo=0 immediately, and no late commit after release.
